// File: rtl/multicycle_ctrl_if.sv
// Bundle of control-side signals for multicycle_ctrl: instruction/data memory
// handshakes, datapath strobes, operand-B mux controls and debug status.
//
// Handshake rule for both memory ports: the controller raises *_req and holds
// it (and dmem_we) steady until it samples the matching *_ready high on a
// rising clock edge; the request drops in the following cycle. *_ready is
// ignored whenever the matching request is low.
interface multicycle_ctrl_if;
   logic [31:0] instr;
   logic        imem_req;
   logic        imem_ready;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ready;
   logic        ir_we;
   logic        pc_we;
   logic        rf_we;
   logic        wb_sel;
   logic        alu_src_sel;
   logic [11:0] imm12;
   logic [3:0]  alu_op;
   logic        illegal;
   logic [2:0]  state;

   // Controller side.
   modport master (
      input  instr, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel,
             alu_src_sel, imm12, alu_op, illegal, state
   );

   // Memory / datapath side.
   modport slave (
      output instr, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel,
             alu_src_sel, imm12, alu_op, illegal, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I subset (R-type ALU, I-type ALU, LW,
// SW). Sequences fetch/decode/execute/memory/writeback, owns a private copy
// of the IR and registers the operand-B mux controls during DECODE so they
// stay stable through EXEC, MEM and WB. Unsupported encodings park the FSM
// in TRAP until reset.
module multicycle_ctrl (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      C_R  = 2'd0,
      C_I  = 2'd1,
      C_LW = 2'd2,
      C_SW = 2'd3
   } cls_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_ir;
   cls_t        r_cls;
   logic        r_alu_src_sel;
   logic [3:0]  r_alu_op;
   logic [11:0] r_imm12;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic        w_legal;
   cls_t        w_cls;
   logic        w_src;
   logic [3:0]  w_op;
   logic [11:0] w_imm;

   assign w_opcode = r_ir[6:0];
   assign w_funct3 = r_ir[14:12];
   assign w_funct7 = r_ir[31:25];

   // Decode the held IR into class, operand-B select, ALU op and immediate.
   always_comb begin
      w_legal = 1'b0;
      w_cls   = C_R;
      w_src   = 1'b0;
      w_op    = 4'd0;
      w_imm   = r_ir[31:20];
      case (w_opcode)
         7'b0110011: begin
            w_cls   = C_R;
            w_src   = 1'b1;
            w_op    = {w_funct7[5], w_funct3};
            // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
            w_legal = (w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
         end
         7'b0010011: begin
            w_cls = C_I;
            w_op  = {(w_funct3 == 3'b101) & w_funct7[5], w_funct3};
            case (w_funct3)
               3'b001:  w_legal = (w_funct7 == 7'b0000000);
               3'b101:  w_legal = (w_funct7 == 7'b0000000) ||
                                  (w_funct7 == 7'b0100000);
               default: w_legal = 1'b1;
            endcase
         end
         7'b0000011: begin
            w_cls   = C_LW;
            w_legal = (w_funct3 == 3'b010);
         end
         7'b0100011: begin
            w_cls   = C_SW;
            w_imm   = {r_ir[31:25], r_ir[11:7]};
            w_legal = (w_funct3 == 3'b010);
         end
         default: w_legal = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Capture the instruction word in the cycle the fetch completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         r_ir <= 32'd0;
      else if ((r_state == S_FETCH) && bus.imem_ready) r_ir <= bus.instr;
   end

   // Decode fields change only at the end of a legal DECODE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cls         <= C_R;
         r_alu_src_sel <= 1'b0;
         r_alu_op      <= 4'd0;
         r_imm12       <= 12'd0;
      end else if ((r_state == S_DECODE) && w_legal) begin
         r_cls         <= w_cls;
         r_alu_src_sel <= w_src;
         r_alu_op      <= w_op;
         r_imm12       <= w_imm;
      end
   end

   // Next-state and strobe/request decode from the registered state.
   always_comb begin
      w_next       = r_state;
      bus.imem_req = 1'b0;
      bus.ir_we    = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      bus.pc_we    = 1'b0;
      bus.rf_we    = 1'b0;
      bus.wb_sel   = 1'b0;
      bus.illegal  = 1'b0;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_we = 1'b1;
               w_next    = S_DECODE;
            end
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
         S_EXEC:   w_next = ((r_cls == C_LW) || (r_cls == C_SW)) ? S_MEM : S_WB;
         S_MEM: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = (r_cls == C_SW);
            if (bus.dmem_ready) begin
               // A store retires here; a load still needs its writeback.
               bus.pc_we = (r_cls == C_SW);
               w_next    = (r_cls == C_SW) ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            bus.rf_we  = 1'b1;
            bus.pc_we  = 1'b1;
            bus.wb_sel = (r_cls == C_LW);
            w_next     = S_FETCH;
         end
         S_TRAP: begin
            bus.illegal = 1'b1;
            w_next      = S_TRAP;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   assign bus.state       = r_state;
   assign bus.alu_src_sel = r_alu_src_sel;
   assign bus.alu_op      = r_alu_op;
   assign bus.imm12       = r_imm12;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl. A transaction-level
// reference decodes each instruction from the ISA rules and the expected
// per-cycle control picture is built from the phase sequence and chosen
// memory wait counts.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_TRAP = 3'd6;

  typedef struct packed {
    logic        legal;
    logic [1:0]  cls;   // 0 R, 1 I-ALU, 2 LW, 3 SW
    logic        src;
    logic [3:0]  op;
    logic [11:0] imm;
  } dec_t;

  logic clk;
  logic rst;
  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [16:0] exp_fields = '0;
  logic        exp_is_r   = 1'b0;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    d  = '0;
    if (w[6:0] == 7'h33) begin
      d.cls = 2'd0; d.src = 1'b1; d.op = {f7[5], f3};
      d.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (w[6:0] == 7'h13) begin
      d.cls = 2'd1; d.imm = w[31:20];
      d.op  = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
      if (f3 == 3'd1)      d.legal = (f7 == 7'h00);
      else if (f3 == 3'd5) d.legal = (f7 == 7'h00) || (f7 == 7'h20);
      else                 d.legal = 1'b1;
    end else if (w[6:0] == 7'h03) begin
      d.cls = 2'd2; d.imm = w[31:20]; d.legal = (f3 == 3'd2);
    end else if (w[6:0] == 7'h23) begin
      d.cls = 2'd3; d.imm = {w[31:25], w[11:7]}; d.legal = (f3 == 3'd2);
    end
    return d;
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [31:0] w;
    logic [11:0] imm;
    logic [2:0]  f3;
    int          c;
    c   = $urandom_range(0, 3);
    imm = 12'($urandom);
    f3  = 3'($urandom);
    w   = $urandom;
    case (c)
      0: begin
        w[6:0] = 7'h33; w[14:12] = f3;
        w[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: begin
        w[6:0] = 7'h13; w[14:12] = f3;
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        w[31:20] = imm;
      end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; w[31:20] = imm; end
      default: begin
        w[6:0] = 7'h23; w[14:12] = 3'd2; w[31:25] = imm[11:5]; w[11:7] = imm[4:0];
      end
    endcase
    return w;
  endfunction

  function automatic logic [10:0] ctl_exp(input logic [2:0] st, input logic ireq,
      input logic irwe, input logic dreq, input logic dwe, input logic pcwe,
      input logic rfwe, input logic wbs, input logic ill);
    return {st, ireq, irwe, dreq, dwe, pcwe, rfwe, wbs, ill};
  endfunction

  function automatic logic [10:0] ctl_obs();
    return {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
            bus.pc_we, bus.rf_we, bus.wb_sel, bus.illegal};
  endfunction

  function automatic logic [16:0] fields_obs();
    return {bus.alu_src_sel, bus.alu_op, exp_is_r ? 12'h000 : bus.imm12};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs unrelated to the current phase get random junk.
  task automatic step_rand();
    @(posedge clk); #1;
    bus.imem_ready = 1'($urandom_range(0, 1));
    bus.dmem_ready = 1'($urandom_range(0, 1));
    bus.instr      = $urandom;
    #1;
  endtask

  task automatic finish_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.instr      = 32'd0;
    #1;
    exp_fields = '0;
    exp_is_r   = 1'b0;
    chk("reset_ctl", 32'(ctl_obs()), 32'd0);
    chk("reset_fields", 32'({bus.alu_src_sel, bus.alu_op, bus.imm12}), 32'd0);
    finish_reset();
  endtask

  // Runs one instruction from its first FETCH cycle. abort_k >= 0 asserts
  // reset during that MEM cycle. trapped reports an illegal encoding.
  task automatic run_instr(input logic [31:0] w, input int iw, input int dw,
                           input int abort_k, output logic trapped);
    dec_t d;
    logic sw;
    d       = ref_dec(w);
    sw      = (d.cls == 2'd3);
    trapped = 1'b0;
    for (int k = 0; k <= iw; k++) begin
      @(posedge clk); #1;
      bus.imem_ready = (k == iw);
      bus.instr      = (k == iw) ? w : $urandom;
      bus.dmem_ready = 1'($urandom_range(0, 1));
      #1;
      chk("fetch_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_FETCH, 1, k == iw, 0, 0, 0, 0, 0, 0)));
      chk("fetch_fields", 32'(fields_obs()), 32'(exp_fields));
    end
    step_rand();
    chk("decode_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("decode_fields", 32'(fields_obs()), 32'(exp_fields));
    if (!d.legal) begin
      for (int k = 0; k < 4; k++) begin
        step_rand();
        chk("trap_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_TRAP, 0, 0, 0, 0, 0, 0, 0, 1)));
      end
      trapped = 1'b1;
      return;
    end
    exp_is_r   = (d.cls == 2'd0);
    exp_fields = {d.src, d.op, exp_is_r ? 12'h000 : d.imm};
    step_rand();
    chk("exec_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("exec_fields", 32'(fields_obs()), 32'(exp_fields));
    if (d.cls == 2'd0 || d.cls == 2'd1) begin
      step_rand();
      chk("wb_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_WB, 0, 0, 0, 0, 1, 1, 0, 0)));
      chk("wb_fields", 32'(fields_obs()), 32'(exp_fields));
      return;
    end
    for (int k = 0; k <= dw; k++) begin
      @(posedge clk); #1;
      bus.dmem_ready = (k == dw);
      bus.imem_ready = 1'($urandom_range(0, 1));
      bus.instr      = $urandom;
      #1;
      chk("mem_ctl", 32'(ctl_obs()),
          32'(ctl_exp(ST_MEM, 0, 0, 1, sw, sw && (k == dw), 0, 0, 0)));
      chk("mem_fields", 32'(fields_obs()), 32'(exp_fields));
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        chk("rst_abort_ctl", 32'(ctl_obs()), 32'd0);
        exp_fields = '0;
        exp_is_r   = 1'b0;
        chk("rst_abort_fields", 32'({bus.alu_src_sel, bus.alu_op, bus.imm12}), 32'd0);
        finish_reset();
        return;
      end
    end
    if (!sw) begin
      step_rand();
      chk("lw_wb_ctl", 32'(ctl_obs()), 32'(ctl_exp(ST_WB, 0, 0, 0, 0, 1, 1, 1, 0)));
      chk("lw_wb_fields", 32'(fields_obs()), 32'(exp_fields));
    end
  endtask

  // ---------------- stimulus sequence ----------------
  initial begin
    logic trapped;
    logic [31:0] w;
    rst = 1'b1;
    bus.instr = 32'd0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    #2;
    do_reset();

    run_instr(32'h002081B3, 0, 0, -1, trapped);   // ADD x3,x1,x2
    run_instr(32'hFFB00093, 1, 0, -1, trapped);   // ADDI x1,x0,-5
    run_instr(32'h402081B3, 0, 0, -1, trapped);   // SUB
    run_instr(32'h4030D093, 2, 0, -1, trapped);   // SRAI x1,x1,3
    run_instr(32'hFE20AE23, 0, 2, -1, trapped);   // SW x2,-4(x1), ready on 3rd MEM cycle
    run_instr(32'h0080A283, 0, 0, -1, trapped);   // LW x5,8(x1), zero wait

    run_instr(32'h40309093, 0, 0, -1, trapped);   // SLLI with funct7=0100000
    chk("slli_trapped", 32'(trapped), 32'd1);
    do_reset();
    run_instr(32'h00000000, 1, 0, -1, trapped);   // all-zero word
    chk("zero_trapped", 32'(trapped), 32'd1);
    do_reset();

    run_instr(32'h0080A283, 0, 5, 1, trapped);    // reset during a load's MEM wait

    for (int n = 0; n < 40; n++) begin
      run_instr(gen_legal(), $urandom_range(0, 3), $urandom_range(0, 3), -1, trapped);
    end

    for (int n = 0; n < 12; n++) begin
      w = (n % 2 == 0) ? $urandom : gen_legal();
      if (n % 4 == 1) w[31:25] = 7'h7F;            // bad funct7 on R/shift forms
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), -1, trapped);
      chk("trap_matches_model", 32'(trapped), 32'(!ref_dec(w).legal));
      if (trapped) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
